// File: rtl/dti_rob_state_entry.sv
// Per-TBU DTI connection-tracking entry: state, captured TID and outstanding-translation count.
// Optional simulation checks are enabled by defining DTI_ROB_ENTRY_CHECK_EN.
module dti_rob_state_entry #(
   parameter int          DATA_W          = 80,
   parameter int          KEEP_W          = 10,
   parameter int          TID_W           = 6,
   parameter int          CNT_W           = 8,
   parameter logic [3:0]  CONDIS_REQ_TYPE = 4'h0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              entry_reset,
   input  logic              entry_con_req,
   input  logic              entry_disconnect_req,
   input  logic              entry_trans_req,
   input  logic              entry_trans_ack,
   input  logic              entry_ack_con,
   input  logic              entry_con_deny,
   input  logic              entry_disconnect_ack,
   input  logic              req_last,
   input  logic [TID_W-1:0]  entry_tid_in,
   input  logic              req_ready,
   output logic              idle,
   output logic [TID_W-1:0]  entry_tid_out,
   output logic              entry_req_valid,
   output logic [DATA_W-1:0] entry_req_data,
   output logic [KEEP_W-1:0] entry_req_keep,
   output logic              entry_req_last
);

   typedef enum logic [1:0] {
      IDLE,
      CONNECTING,
      CONNECTED,
      DISCONNECTING
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [TID_W-1:0]   tid;
   logic               inc;
   logic               dec;
   logic               cnt_full;
   logic               cnt_zero;

   assign inc      = entry_trans_req && req_last;
   assign dec      = entry_trans_ack;
   assign cnt_full = (cnt == '1);
   assign cnt_zero = (cnt == '0);

   assign idle            = (state == IDLE);
   assign entry_tid_out   = tid;
   assign entry_req_valid = entry_reset && (state == CONNECTED) && cnt_zero;
   // Self-generated CONDIS_REQ: type in [3:0], state bit [4] = 0 (disconnect).
   assign entry_req_data  = DATA_W'(CONDIS_REQ_TYPE);
   assign entry_req_keep  = KEEP_W'(4'hF);
   assign entry_req_last  = 1'b1;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         tid   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (entry_con_req) begin
                  state <= CONNECTING;
                  tid   <= entry_tid_in;
                  cnt   <= '0;
               end
            end
            CONNECTING: begin
               if (entry_ack_con)
                  state <= CONNECTED;
               else if (entry_con_deny)
                  state <= IDLE;
            end
            CONNECTED: begin
               if (inc && !dec && !cnt_full)
                  cnt <= cnt + 1'b1;
               else if (dec && !inc && !cnt_zero)
                  cnt <= cnt - 1'b1;
               if (entry_disconnect_req || (entry_req_valid && req_ready))
                  state <= DISCONNECTING;
            end
            DISCONNECTING: begin
               if (dec && !cnt_zero)
                  cnt <= cnt - 1'b1;
               if (entry_disconnect_ack)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DTI_ROB_ENTRY_CHECK_EN
   logic [31:0] cyc;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         cyc <= '0;
      end else begin
         cyc <= cyc + 1'b1;
         if (entry_con_req && state != IDLE)
            $display("ENTRY_ERR cycle %0d: con_req outside IDLE", cyc);
         if ((entry_ack_con || entry_con_deny) && state != CONNECTING && state != CONNECTED
             && state != DISCONNECTING)
            $display("ENTRY_ERR cycle %0d: ack/deny outside CONNECTING", cyc);
         if (entry_con_deny && state != CONNECTING)
            $display("ENTRY_ERR cycle %0d: ack/deny outside CONNECTING", cyc);
         if (state == CONNECTED && inc && !dec && cnt_full)
            $display("ENTRY_ERR cycle %0d: counter overflow", cyc);
         if (cnt_zero && dec && ((state == CONNECTED && !inc) || state == DISCONNECTING))
            $display("ENTRY_ERR cycle %0d: counter underflow", cyc);
         if (entry_trans_req && state == IDLE)
            $display("ENTRY_ERR cycle %0d: trans_req while IDLE", cyc);
      end
   end
`endif

endmodule

// File: tb/tb_dti_rob_state_entry.sv
// Self-checking bench for dti_rob_state_entry: directed test-plan sequences plus random stimulus
// checked against a flag-based behavioural model of the connection lifecycle.
module tb_dti_rob_state_entry;

   localparam int DATA_W  = 80;
   localparam int KEEP_W  = 10;
   localparam int TID_W   = 6;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              entry_reset;
   logic              entry_con_req;
   logic              entry_disconnect_req;
   logic              entry_trans_req;
   logic              entry_trans_ack;
   logic              ack;
   logic              entry_con_deny;
   logic              req_last;
   logic [TID_W-1:0]  entry_tid_in;
   logic              req_ready;
   logic              idle;
   logic [TID_W-1:0]  entry_tid_out;
   logic              entry_req_valid;
   logic [DATA_W-1:0] entry_req_data;
   logic [KEEP_W-1:0] entry_req_keep;
   logic              entry_req_last;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: an entry is "busy" once allocated; "up" after the connect ack; "leaving" once disconnecting.
   bit m_busy, m_up, m_leaving;
   int m_cnt;
   int m_tid;

   always #5 clk = ~clk;

   dti_rob_state_entry #(
      .DATA_W(DATA_W), .KEEP_W(KEEP_W), .TID_W(TID_W), .CNT_W(CNT_W), .CONDIS_REQ_TYPE(4'h0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .entry_reset(entry_reset), .entry_con_req(entry_con_req),
      .entry_disconnect_req(entry_disconnect_req), .entry_trans_req(entry_trans_req),
      .entry_trans_ack(entry_trans_ack), .entry_ack_con(ack), .entry_con_deny(entry_con_deny),
      .entry_disconnect_ack(ack), .req_last(req_last), .entry_tid_in(entry_tid_in),
      .req_ready(req_ready), .idle(idle), .entry_tid_out(entry_tid_out),
      .entry_req_valid(entry_req_valid), .entry_req_data(entry_req_data),
      .entry_req_keep(entry_req_keep), .entry_req_last(entry_req_last)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_valid();
      return entry_reset && m_up && (m_cnt == 0);
   endfunction

   task automatic model_step();
      bit v;
      int n;
      v = model_valid();
      if (rst_n) begin
         m_busy = 0; m_up = 0; m_leaving = 0; m_cnt = 0; m_tid = 0;
      end else if (!m_busy) begin
         if (entry_con_req) begin
            m_busy = 1; m_tid = entry_tid_in; m_cnt = 0;
         end
      end else if (!m_up && !m_leaving) begin
         if (ack) m_up = 1;
         else if (entry_con_deny) m_busy = 0;
      end else if (m_up) begin
         n = m_cnt + int'(entry_trans_req && req_last) - int'(entry_trans_ack);
         m_cnt = (n < 0) ? 0 : (n > CNT_MAX) ? CNT_MAX : n;
         if (entry_disconnect_req || (v && req_ready)) begin
            m_up = 0; m_leaving = 1;
         end
      end else begin
         if (entry_trans_ack && m_cnt > 0) m_cnt = m_cnt - 1;
         if (ack) begin
            m_busy = 0; m_leaving = 0;
         end
      end
   endtask

   // One clock: combinational checks mid-cycle, model update at the edge, registered checks after it.
   task automatic cycle();
      @(negedge clk);
      check("req_valid", 64'(entry_req_valid), 64'(model_valid()));
      if (model_valid()) begin
         check("req_data_lo", 64'(entry_req_data[4:0]), 64'h0);
         check("req_data_hi", 64'(|entry_req_data[DATA_W-1:5]), 64'h0);
         check("req_keep", 64'(entry_req_keep), 64'h00F);
         check("req_last", 64'(entry_req_last), 64'h1);
      end
      @(posedge clk);
      model_step();
      #1;
      check("idle", 64'(idle), 64'(!m_busy));
      check("tid", 64'(entry_tid_out), 64'(m_tid));
      check("cnt", 64'(dut.cnt), 64'(m_cnt));
   endtask

   task automatic clr();
      rst_n = 0; entry_reset = 0; entry_con_req = 0; entry_disconnect_req = 0;
      entry_trans_req = 0; entry_trans_ack = 0; ack = 0; entry_con_deny = 0;
      req_last = 0; entry_tid_in = '0; req_ready = 0;
   endtask

   task automatic connect(input int tid);
      clr(); entry_con_req = 1; entry_tid_in = TID_W'(tid); cycle();
      clr(); ack = 1; cycle();
      clr();
   endtask

   task automatic trans(input int n, input bit last, input bit rst_sel);
      for (int i = 0; i < n; i++) begin
         clr(); entry_reset = rst_sel; entry_trans_req = 1; req_last = last; cycle();
      end
      clr();
   endtask

   task automatic acks(input int n, input bit rst_sel);
      for (int i = 0; i < n; i++) begin
         clr(); entry_reset = rst_sel; entry_trans_ack = 1; cycle();
      end
      clr();
   endtask

   initial begin
      m_busy = 0; m_up = 0; m_leaving = 0; m_cnt = 0; m_tid = 0;
      clr(); rst_n = 1; cycle(); cycle();
      clr();
      check("reset_idle", 64'(idle), 64'h1);

      // Basic connect / disconnect with TID 5.
      clr(); entry_con_req = 1; entry_tid_in = 6'd5; cycle();
      check("tp_tid5", 64'(entry_tid_out), 64'd5);
      check("tp_busy", 64'(idle), 64'h0);
      clr(); ack = 1; cycle();
      clr(); entry_disconnect_req = 1; cycle();
      clr(); ack = 1; cycle();
      check("tp_disc_idle", 64'(idle), 64'h1);

      // Connect denied.
      clr(); entry_con_req = 1; entry_tid_in = 6'd9; cycle();
      clr(); entry_con_deny = 1; cycle();
      check("tp_deny_idle", 64'(idle), 64'h1);

      // Translation counting, including a non-last beat and a simultaneous req+ack.
      connect(12);
      trans(3, 1, 0);
      trans(1, 0, 0);
      check("tp_cnt3", 64'(dut.cnt), 64'd3);
      clr(); entry_trans_req = 1; req_last = 1; entry_trans_ack = 1; cycle();
      check("tp_cnt3_both", 64'(dut.cnt), 64'd3);
      acks(3, 0);
      check("tp_cnt0", 64'(dut.cnt), 64'd0);

      // Partial-reset drain: valid only once the counter reaches zero, then handshake.
      trans(2, 1, 1);
      clr(); entry_reset = 1; cycle();
      acks(2, 1);
      clr(); entry_reset = 1; cycle();
      clr(); entry_reset = 1; req_ready = 1; cycle();
      check("tp_drain_valid_gone", 64'(entry_req_valid), 64'h0);
      clr(); ack = 1; cycle();
      check("tp_drain_idle", 64'(idle), 64'h1);

      // Selected while CONNECTING produces no request.
      clr(); entry_con_req = 1; entry_tid_in = 6'd3; cycle();
      clr(); entry_reset = 1; req_ready = 1; cycle(); cycle();
      clr(); entry_con_deny = 1; cycle();

      // Reset mid-operation.
      connect(33);
      trans(4, 1, 0);
      clr(); rst_n = 1; entry_trans_req = 1; req_last = 1; cycle();
      check("tp_rst_tid", 64'(entry_tid_out), 64'h0);
      check("tp_rst_idle", 64'(idle), 64'h1);

      // Counter saturation at both bounds.
      connect(7);
      trans(CNT_MAX + 4, 1, 0);
      check("sat_hi", 64'(dut.cnt), 64'(CNT_MAX));
      acks(CNT_MAX + 4, 0);
      check("sat_lo", 64'(dut.cnt), 64'd0);
      clr(); entry_disconnect_req = 1; cycle();
      acks(2, 0);
      clr(); ack = 1; cycle();

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         clr();
         rst_n                = ($urandom_range(0, 99) == 0);
         entry_reset          = ($urandom_range(0, 2) == 0);
         entry_con_req        = ($urandom_range(0, 3) == 0);
         entry_disconnect_req = ($urandom_range(0, 15) == 0);
         entry_trans_req      = ($urandom_range(0, 1) == 0);
         req_last             = ($urandom_range(0, 1) == 0);
         entry_trans_ack      = ($urandom_range(0, 2) == 0);
         ack                  = ($urandom_range(0, 7) == 0);
         entry_con_deny       = ($urandom_range(0, 7) == 0);
         req_ready            = ($urandom_range(0, 1) == 0);
         entry_tid_in         = TID_W'($urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dti_rob_state_entry.md
# dti_rob_state_entry

Per-TBU connection-tracking entry for the DTI protocol repeater. It records one TBU's DTI connection state, captured TID and outstanding translation count. During partial reset it drains its translations and then emits its own disconnect request toward the converter. The repeater instantiates one entry per TBU slot and arbitrates allocation and reset across them.

## Interface
- `DATA_W`, 80: width of the generated request data (CUSTOM_DATA_WIDTH).
- `KEEP_W`, 10: width of the generated request keep.
- `TID_W`, 6: TBU ID width.
- `CNT_W`, 8: outstanding-translation counter width.
- `CONDIS_REQ_TYPE`, 4'h0: DTI_TBU_CONDIS_REQ message type code.

- `clk` input 1: clock.
- `rst_n` input 1: reset. Synchronous, active-high (asserted = 1); the name follows codebase convention.
- `entry_reset` input 1: this entry is selected by the partial-reset arbiter.
- `entry_con_req` input 1: accepted connect request allocated to this entry.
- `entry_disconnect_req` input 1: accepted TBU disconnect request matching this TID.
- `entry_trans_req` input 1: accepted non-CONDIS request beat matching this TID.
- `entry_trans_ack` input 1: accepted non-CONDIS response matching this TID.
- `entry_ack_con` input 1: CONDIS_ACK with state=1 matching this TID.
- `entry_con_deny` input 1: CONDIS_ACK with state=0 matching this TID.
- `entry_disconnect_ack` input 1: CONDIS_ACK with state=1 matching this TID.
- `req_last` input 1: current request beat is the last beat.
- `entry_tid_in` input TID_W: TID of the current request.
- `req_ready` input 1: converter accepts the request.
- `idle` output 1: entry is free.
- `entry_tid_out` output TID_W: captured TID.
- `entry_req_valid`, `entry_req_data` (DATA_W), `entry_req_keep` (KEEP_W), `entry_req_last`: outputs carrying the generated disconnect request.

## Operation
- States: IDLE, CONNECTING, CONNECTED, DISCONNECTING.
- IDLE:
  - `entry_con_req` → CONNECTING.
  - Same cycle: capture `entry_tid_in`; clear the counter.
- CONNECTING:
  - `entry_ack_con` → CONNECTED.
  - `entry_con_deny` → IDLE.
- CONNECTED:
  - `entry_trans_req && req_last` increments the counter.
  - `entry_trans_ack` decrements the counter.
  - Both in the same cycle leave the counter unchanged.
  - `entry_disconnect_req` → DISCONNECTING.
- DISCONNECTING:
  - `entry_disconnect_ack` → IDLE.
  - `entry_trans_ack` still decrements the counter.
- In any state other than the one listed for it, an event is ignored.
- `entry_ack_con` and `entry_disconnect_ack` arrive on identical conditions; the current state alone determines the meaning.
- `idle` = (state == IDLE).
- Partial-reset drain:
  - `entry_req_valid` = `entry_reset` && CONNECTED && counter == 0. This is combinational.
  - Generated request:
    - `entry_req_data`: [3:0] = CONDIS_REQ_TYPE, [4] = 0; all other bits 0.
    - `entry_req_keep` = 'h00F.
    - `entry_req_last` = 1.
  - Handshake: `entry_req_valid && req_ready` → DISCONNECTING.
  - While selected in CONNECTING, the entry waits for the ack or deny. It does not generate a request.
  - While selected in CONNECTED with counter > 0, `entry_req_valid` stays 0 until the counter drains to zero.
- The counter saturates at both bounds: no wrap past all-ones, no decrement below 0.

## Timing
- `rst_n` = 1 at a clock edge sets:
  - state = IDLE, `idle` = 1
  - counter = 0, `entry_tid_out` = 0
  - `entry_req_valid` = 0
- Reset overrides all events in the same cycle.
- State, TID and counter update on the clock edge after the qualifying event. There is one cycle of latency to `idle` and `entry_tid_out`.
- `entry_req_valid`/`data`/`keep`/`last` are combinational from registered state and `entry_reset`. They have no latency.
- `entry_req_valid` may drop without a handshake when `entry_reset` deasserts. The repeater tolerates this because `partial_reset` gates the mux.
- The last `entry_trans_ack` makes the counter 0 at edge N. `entry_req_valid` rises in cycle N+1 if `entry_reset` is held.

## Configuration
- `DTI_ROB_ENTRY_CHECK_EN`:
  - Defined: simulation-only checks `$display` an "ENTRY_ERR" line with the cycle count for each of:
    - `entry_con_req` outside IDLE
    - `entry_ack_con`/`entry_con_deny` outside CONNECTING
    - counter overflow or underflow
    - `entry_trans_req` while IDLE
  - Undefined: no check logic; identical synthesized RTL.

## Test plan
- Basic connect/disconnect:
  - Reset, then `entry_con_req` with tid=5: next cycle `idle`=0, `entry_tid_out`=5.
  - `entry_ack_con` → CONNECTED.
  - `entry_disconnect_req`, then `entry_disconnect_ack`: `idle`=1.
- Connect denied: `entry_con_req` then `entry_con_deny` → `idle`=1, counter = 0.
- Translation count:
  - Three `entry_trans_req` with `req_last`=1, one with `req_last`=0: counter = 3.
  - A simultaneous req+ack leaves it at 3.
  - Three acks → 0.
- Partial-reset drain:
  - CONNECTED with counter = 2, `entry_reset`=1: `entry_req_valid`=0.
  - After 2 acks, `entry_req_valid`=1, data[4:0]=5'h00, keep=10'h00F, last=1.
  - `req_ready`=1 → DISCONNECTING; `entry_disconnect_ack` → `idle`=1.
- Reset mid-operation: CONNECTED with counter = 4 and `rst_n`=1 → next cycle `idle`=1, tid = 0, counter = 0, valid = 0.
